// File: rtl/nibble_packer.sv
// nibble_packer
//
// Packs a stream of FIELD_W-bit fields into FIELD_W*LANES-bit words. The
// first field of a word lands in the most significant lane. A field offered
// with in_last_i closes the word early, and the unfilled low lanes read zero.
// The finished word sits in a single output register until downstream takes it.
//
// Ports:
//   clk_i        clock, rising edge active
//   rst_n_i      asynchronous active-low reset
//   in_valid_i   a field is offered
//   in_ready_o   a field is accepted this cycle (depends on output state only)
//   in_data_i    offered field
//   in_last_i    offered field closes the current word
//   out_valid_o  output register holds a word
//   out_ready_i  downstream takes the word this cycle
//   out_data_o   packed word, lane 0 in the top FIELD_W bits
//   out_count_o  number of real fields in out_data_o (1..LANES)
module nibble_packer #(
    parameter int FIELD_W = 4,
    parameter int LANES   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [FIELD_W-1:0]         in_data_i,
    input  logic                       in_last_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [FIELD_W*LANES-1:0]   out_data_o,
    output logic [2:0]                 out_count_o
);

    localparam int WORD_W = FIELD_W * LANES;
    localparam int FILL_W = (LANES > 1) ? $clog2(LANES) : 1;

    // Accumulator and fill index; acc_r only ever holds lanes below fill_r,
    // all higher lanes are zero because it is cleared on every completion.
    logic [WORD_W-1:0] acc_r;
    logic [FILL_W-1:0] fill_r;

    // Output register
    logic [WORD_W-1:0] out_data_r;
    logic [2:0]        out_count_r;
    logic              out_valid_r;

    // Next-state values
    logic [WORD_W-1:0] acc_n_s;
    logic [FILL_W-1:0] fill_n_s;
    logic [WORD_W-1:0] out_data_n_s;
    logic [2:0]        out_count_n_s;
    logic              out_valid_n_s;

    logic              in_ready_s;
    logic              in_fire_s;
    logic              complete_s;
    logic [WORD_W-1:0] merged_s;

    // Ready depends only on output-side state so it cannot loop back through
    // in_data_i/in_last_i.
    assign in_ready_s = !out_valid_r || out_ready_i;
    assign in_fire_s  = in_valid_i && in_ready_s;
    assign complete_s = in_last_i || (fill_r == FILL_W'(LANES - 1));

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = out_valid_r;
    assign out_data_o  = out_data_r;
    assign out_count_o = out_count_r;

    // Accumulator with the offered field dropped into lane fill_r.
    always_comb begin
        merged_s = acc_r;
        for (int i = 0; i < LANES; i++) begin
            if (FILL_W'(i) == fill_r) begin
                merged_s[WORD_W-1-i*FIELD_W -: FIELD_W] = in_data_i;
            end else begin
                merged_s[WORD_W-1-i*FIELD_W -: FIELD_W] = acc_r[WORD_W-1-i*FIELD_W -: FIELD_W];
            end
        end
    end

    // Next-state for accumulator and output register.
    always_comb begin
        acc_n_s       = acc_r;
        fill_n_s      = fill_r;
        out_data_n_s  = out_data_r;
        out_count_n_s = out_count_r;

        // An output fire frees the register; a completing fire below may
        // immediately refill it, keeping valid high with no gap.
        if (out_valid_r && out_ready_i) begin
            out_valid_n_s = 1'b0;
        end else begin
            out_valid_n_s = out_valid_r;
        end

        if (in_fire_s) begin
            if (complete_s) begin
                out_data_n_s  = merged_s;
                out_count_n_s = 3'(fill_r) + 3'd1;
                out_valid_n_s = 1'b1;
                acc_n_s       = {WORD_W{1'b0}};
                fill_n_s      = {FILL_W{1'b0}};
            end else begin
                acc_n_s  = merged_s;
                fill_n_s = fill_r + FILL_W'(1);
            end
        end else begin
            acc_n_s  = acc_r;
            fill_n_s = fill_r;
        end
    end

    // State registers; reset discards any partial or pending word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_r       <= {WORD_W{1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            out_data_r  <= {WORD_W{1'b0}};
            out_count_r <= 3'd0;
            out_valid_r <= 1'b0;
        end else begin
            acc_r       <= acc_n_s;
            fill_r      <= fill_n_s;
            out_data_r  <= out_data_n_s;
            out_count_r <= out_count_n_s;
            out_valid_r <= out_valid_n_s;
        end
    end

endmodule
